// File: rtl/cnu_msg_expand_pkg.sv
// rtl/cnu_msg_expand_pkg.sv - shared CNU constants and FSM state encoding
package cnu_msg_expand_pkg;

  localparam int QUAN_SIZE_DEF = 3;
  localparam int DC_DEF        = 6;
  localparam int IDX_W_DEF     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/cnu_msg_expand_if.sv
// rtl/cnu_msg_expand_if.sv - compressed record in, per-edge extrinsic message out
interface cnu_msg_expand_if #(
  parameter int QUAN_SIZE = 3,
  parameter int DC        = 6,
  parameter int IDX_W     = 3
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [QUAN_SIZE-1:0] min1;
  logic [QUAN_SIZE-1:0] min2;
  logic [IDX_W-1:0]     min_index;
  logic                 sign_prod;
  logic [DC-1:0]        sign_vec;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic [QUAN_SIZE-1:0] out_mag;
  logic [IDX_W-1:0]     out_edge;
  logic                 out_last;

  modport master (
    output in_valid, min1, min2, min_index, sign_prod, sign_vec, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_edge, out_last
  );

  modport slave (
    input  in_valid, min1, min2, min_index, sign_prod, sign_vec, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_edge, out_last
  );

endinterface

// File: rtl/cnu_msg_expand.sv
// rtl/cnu_msg_expand.sv - expands a min1/min2 check-node record into DC extrinsic messages
module cnu_msg_expand
  import cnu_msg_expand_pkg::*;
#(
  parameter int QUAN_SIZE = QUAN_SIZE_DEF,
  parameter int DC        = DC_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  cnu_msg_expand_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_EDGE = IDX_W'(DC - 1);

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     cnt;
  logic [QUAN_SIZE-1:0] min1_q;
  logic [QUAN_SIZE-1:0] min2_q;
  logic [IDX_W-1:0]     min_index_q;
  logic                 sign_prod_q;
  logic [DC-1:0]        sign_vec_q;

  logic                 is_last;
  logic [DC-1:0]        sign_shift;
  logic                 in_hs;
  logic                 out_hs;

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode only from registered state, so an async reset blanks them at once.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sign  = 1'b0;
    bus.out_mag   = '0;
    bus.out_edge  = '0;
    bus.out_last  = 1'b0;
    is_last       = (cnt == LAST_EDGE);
    sign_shift    = sign_vec_q >> cnt;
    case (state)
      IDLE: begin
        bus.in_ready = ~rst;
        if (bus.in_valid && !rst) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_edge  = cnt;
        bus.out_last  = is_last;
        bus.out_mag   = (cnt == min_index_q) ? min2_q : min1_q;
        bus.out_sign  = sign_prod_q ^ sign_shift[0];
        bus.in_ready  = is_last & bus.out_ready & ~rst;
        if (is_last && bus.out_ready) begin
          state_nxt = bus.in_valid ? EMIT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A reload on the last beat restarts at edge 0 with no idle cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      min1_q      <= '0;
      min2_q      <= '0;
      min_index_q <= '0;
      sign_prod_q <= 1'b0;
      sign_vec_q  <= '0;
    end else if (in_hs) begin
      cnt         <= '0;
      min1_q      <= bus.min1;
      min2_q      <= bus.min2;
      min_index_q <= bus.min_index;
      sign_prod_q <= bus.sign_prod;
      sign_vec_q  <= bus.sign_vec;
    end else if (out_hs && !is_last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/cnu_msg_expand.md
CNU_MSG_EXPAND -- requirements
Module: cnu_msg_expand

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 3, meaning the magnitude width of a message.
REQ-002 SHALL have parameter DC, default 6, meaning the check-node degree (edges per check node).
REQ-003 SHALL have parameter IDX_W, default 3, meaning the edge-index width, equal to ceil(log2(DC)).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports:
  sys_clk  input  1  single clock, rising edge
  rst  input  1  asynchronous active-high reset
  in_valid  input  1  compressed check-node record present
  in_ready  output  1  record accepted when in_valid & in_ready
  min1  input  QUAN_SIZE  smallest input magnitude
  min2  input  QUAN_SIZE  second-smallest input magnitude
  min_index  input  IDX_W  edge index holding min1 (argmin)
  sign_prod  input  1  XOR of all DC input signs
  sign_vec  input  DC  per-edge input signs; bit j belongs to edge j
  out_valid  output  1  extrinsic message present
  out_ready  input  1  message consumed when out_valid & out_ready
  out_sign  output  1  extrinsic sign of the current edge
  out_mag  output  QUAN_SIZE  extrinsic magnitude of the current edge
  out_edge  output  IDX_W  edge index of the current message
  out_last  output  1  high on the edge DC-1 beat

Function
REQ-006 SHALL capture min1, min2, min_index, sign_prod and sign_vec into internal registers on an input handshake.
REQ-007 SHALL have two states: IDLE (no record held) and EMIT (record held, edges being emitted).
REQ-008 SHALL move from IDLE to EMIT on an input handshake and load the edge counter with 0.
REQ-009 SHALL, in EMIT, drive out_valid=1, out_edge=counter, and out_last=1 only when counter==DC-1.
REQ-010 SHALL drive out_mag = min2 when counter==min_index, and min1 otherwise.
REQ-011 SHALL drive out_sign = sign_prod XOR sign_vec[counter].
REQ-012 SHALL increment the counter on each output handshake where counter<DC-1.
REQ-013 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-014 SHALL assert in_ready in IDLE, and in EMIT only when out_last & out_ready are both high.
REQ-015 SHALL, on the last-beat handshake, reload a new record if in_valid=1 and restart at edge 0 in the next cycle with no bubble; otherwise it SHALL return to IDLE.
REQ-016 SHALL output the first message of a record in the cycle after acceptance, giving a latency of 1 cycle; throughput SHALL be DC cycles per record when out_ready is held high.
REQ-017 SHALL make no edge receive min2 when min_index>=DC; every edge then receives min1.
REQ-018 SHALL pass through min2<min1 unchanged, with no checking or reordering.
REQ-019 SHALL drive out_sign, out_mag, out_edge and out_last to 0 in IDLE.

Reset
REQ-020 SHALL, on rst assertion (including mid-record), immediately enter IDLE, clear the counter and all captured registers, and force out_valid=0, out_last=0 and all outputs to 0; any partial record SHALL be discarded.
REQ-021 SHALL drive in_ready=1 from the first clock edge after rst deasserts.

Structure
REQ-022 SHALL place the state encoding (IDLE, EMIT) and default QUAN_SIZE/DC/IDX_W constants in the shared CNU package.
REQ-023 SHALL be a single module with no sub-modules; the magnitude select is one comparator plus a 2:1 multiplexer.

Verification
REQ-024 Single record: min1=2, min2=5, min_index=3, sign_prod=1, sign_vec=6'b000101, out_ready=1 -> 6 beats on consecutive cycles; mags 2,2,2,5,2,2; signs 0,1,0,1,1,1; out_last only on edge 5.
REQ-025 Backpressure: same record, out_ready low on the edge-2 beat for 3 cycles -> edge-2 message held stable for 3 cycles, then edges 3..5 follow; no beat lost or duplicated.
REQ-026 Back-to-back: second record (min1=1, min2=7, min_index=0) valid during the first record's last beat -> in_ready=1 on that beat; next cycle edge 0 carries mag 7; no idle cycle.
REQ-027 Out-of-range index: min_index=7, min1=4, min2=6 -> all 6 beats mag 4.
REQ-028 Reset mid-record: rst asserted during edge 3 -> out_valid=0 asynchronously; after release in_ready=1; a new record then starts at edge 0.
REQ-029 Random stimulus with random out_ready -> bench compares every beat against a reference model (REQ-010, REQ-011) and checks exactly DC beats per accepted record.
